// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

   localparam int          DIV_WIDTH  = 32;
   localparam int          DIV_ITERS  = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic             q_bit
);

   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_trial;

   // rem < divisor always holds, so the WIDTH+1 bit difference cannot overflow
   assign w_shifted = {rem, dvd_msb};
   assign w_trial   = w_shifted - {1'b0, divisor};
   assign q_bit     = ~w_trial[WIDTH];
   assign next_rem  = q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : Iterative signed/unsigned divider, RISC-V DIV/REM semantics.
//               DIV_FAST_SPECIAL_EN: divide-by-zero and overflow finish in 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam logic [WIDTH-1:0] C_ZERO_Q  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       r_state, w_next;
   logic [WIDTH-1:0] r_rem, r_dvd, r_div;
   logic [WIDTH-1:0] r_spec_q, r_spec_r;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign_q, r_sign_r, r_special;

   logic             w_accept, w_neg_a, w_neg_b, w_div_zero, w_ovf, w_special, w_last;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_next_rem;
   logic             w_q_bit;

   // A start coinciding with done is refused so a new request lands no earlier than the cycle after
   assign w_accept   = (r_state == IDLE) && start && !done;
   assign w_neg_a    = is_signed & a[WIDTH-1];
   assign w_neg_b    = is_signed & b[WIDTH-1];
   assign w_mag_a    = w_neg_a ? (~a + 1'b1) : a;
   assign w_mag_b    = w_neg_b ? (~b + 1'b1) : b;
   assign w_div_zero = (b == '0);
   assign w_ovf      = is_signed && (a == C_INT_MIN) && (b == C_ZERO_Q);
   assign w_special  = w_div_zero | w_ovf;
   assign w_last     = (r_cnt == CNT_W'(WIDTH-1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (r_rem),
      .dvd_msb  (r_dvd[WIDTH-1]),
      .divisor  (r_div),
      .next_rem (w_next_rem),
      .q_bit    (w_q_bit)
   );

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) begin
`ifdef DIV_FAST_SPECIAL_EN
            w_next = w_special ? FIN : CALC;
`else
            w_next = CALC;
`endif
         end
         CALC:    if (w_last) w_next = FIN;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         r_rem     <= '0;
         r_dvd     <= '0;
         r_div     <= '0;
         r_cnt     <= '0;
         r_sign_q  <= 1'b0;
         r_sign_r  <= 1'b0;
         r_special <= 1'b0;
         r_spec_q  <= '0;
         r_spec_r  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         q         <= '0;
         r         <= '0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE: if (w_accept) begin
               r_rem     <= '0;
               r_dvd     <= w_mag_a;
               r_div     <= w_mag_b;
               r_cnt     <= '0;
               r_sign_q  <= w_neg_a ^ w_neg_b;
               r_sign_r  <= w_neg_a;
               r_special <= w_special;
               r_spec_q  <= w_div_zero ? C_ZERO_Q : C_INT_MIN;
               r_spec_r  <= w_div_zero ? a : '0;
               busy      <= 1'b1;
            end
            CALC: begin
               // Dividend bits shift out the top while quotient bits fill in from the bottom
               r_rem <= w_next_rem;
               r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
               r_cnt <= r_cnt + 1'b1;
            end
            FIN: begin
               if (r_special) begin
                  q <= r_spec_q;
                  r <= r_spec_r;
               end else begin
                  q <= r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
                  r <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
               end
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module      : tb_div_seq
// Description : Scoreboard bench for div_seq against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] q, r;

   div_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clock     (clock),
      .rstn      (rstn),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .q         (q),
      .r         (r)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           lat;
      int           t0;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] held_q = '0;
   logic [W-1:0] held_r = '0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on wide signed integers plus the two defined corner cases
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                 output logic [W-1:0] mq, output logic [W-1:0] mr);
      longint sa, sd, qq, rr;
      if (mb == '0) begin
         mq = '1;
         mr = ma;
      end else if (ms) begin
         sa = longint'($signed(ma));
         sd = longint'($signed(mb));
         qq = sa / sd;
         rr = sa % sd;
         mq = qq[W-1:0];
         mr = rr[W-1:0];
      end else begin
         mq = ma / mb;
         mr = ma % mb;
      end
   endfunction

   function automatic bit is_special(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
      return (mb == '0) || (ms && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF);
   endfunction

   always @(negedge clock) begin
      if (!rstn) begin
         held_q = '0;
         held_r = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: q=%h r=%h with no request outstanding", q, r);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", q, e.q);
            chk("remainder", r, e.r);
            chk("latency", W'(cyc - e.t0), W'(e.lat));
            held_q = e.q;
            held_r = e.r;
         end
      end else begin
         chk("q_hold", q, held_q);
         chk("r_hold", r, held_r);
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        output int lat);
      logic [W-1:0] eq, er;
      exp_t         e;
      model(ia, ib, is, eq, er);
`ifdef DIV_FAST_SPECIAL_EN
      lat = is_special(ia, ib, is) ? 1 : 33;
`else
      lat = 33;
`endif
      @(negedge clock);
      a = ia;
      b = ib;
      is_signed = is;
      start = 1'b1;
      e.q = eq;
      e.r = er;
      e.lat = lat;
      e.t0 = cyc + 1;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(output int busy_cnt, output bit ok);
      int n;
      n = 0;
      busy_cnt = 0;
      ok = 1'b0;
      while (n < 100) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         n++;
         @(negedge clock);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL timeout: no done within 100 cycles");
      end
   endtask

   task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
      int lat, bc;
      bit ok;
      issue(ia, ib, is, lat);
      wait_done(bc, ok);
      if (ok) begin
         chk("busy_cycles", W'(bc), W'(lat));
         chk("busy_at_done", W'(busy), '0);
      end
   endtask

   initial begin
      int           lat, bc;
      bit           ok;
      logic [W-1:0] ra, rb;
      logic         rs;

      repeat (3) @(negedge clock);
      chk("reset_q", q, '0);
      chk("reset_r", r, '0);
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);
      rstn = 1'b1;

      run(32'd100, 32'd7, 1'b0);
      run(32'hFFFF_FFF9, 32'd2, 1'b1);
      run(32'd7, 32'hFFFF_FFFE, 1'b1);
      run(32'h1234_5678, 32'd0, 1'b1);
      run(32'h1234_5678, 32'd0, 1'b0);
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run(32'hFFFF_FFFF, 32'd1, 1'b0);
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      // Starts while busy and during the done cycle must both be dropped
      issue(32'd1000, 32'd9, 1'b0, lat);
      repeat (4) @(negedge clock);
      start = 1'b1;
      a = 32'd5;
      b = 32'd1;
      @(negedge clock);
      start = 1'b0;
      wait_done(bc, ok);
      if (ok) begin
         start = 1'b1;
         a = 32'd77;
         b = 32'd3;
         @(negedge clock);
         start = 1'b0;
         chk("busy_after_done_start", W'(busy), '0);
         repeat (40) @(negedge clock);
         chk("still_idle", W'(busy), '0);
      end

      // Asynchronous reset in the middle of a division
      issue(32'hDEAD_BEEF, 32'd3, 1'b0, lat);
      repeat (9) @(negedge clock);
      #2 rstn = 1'b0;
      sb.delete();
      #1;
      chk("abort_q", q, '0);
      chk("abort_r", r, '0);
      chk("abort_busy", W'(busy), '0);
      chk("abort_done", W'(done), '0);
      repeat (3) @(negedge clock);
      #2 rstn = 1'b1;
      repeat (40) @(negedge clock);
      chk("idle_after_abort", W'(busy), '0);
      run(32'hDEAD_BEEF, 32'd3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
            2: rb = W'($urandom_range(1, 20));
            3: rb = 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            default: ;
         endcase
         run(ra, rb, rs);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      repeat (40) @(negedge clock);
      chk("scoreboard_empty", W'(sb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
